updown_counter_mod: RTL

- Parametrised up/down counter that succeeds the fixed 4-bit up/down counter with load.
- Width is configurable. The count range is set by a run-time modulo limit, and the step size is programmable.
- Each run either wraps or saturates at the range ends, selected by a mode input.
- Provides registered terminal-event pulses and a sticky overflow/underflow flag for use by timers and sequencers elsewhere in the design.

---
 rtl/updown_counter_mod.sv | 105 ++++++++++
 1 files changed

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with run-time modulo limit, programmable step,
// wrap/saturate modes, registered terminal pulse and sticky over/underflow flags.
module updown_counter_mod #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf,
    output logic             udf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             ovf_set, udf_set;

    // Range arithmetic is carried in WIDTH+1 bits so limit+1 never overflows.
    logic [WIDTH:0] lim_x, lim_p1, step_x, cnt_x, s_eff;
    logic [WIDTH:0] sum_up, wrap_up, diff_dn, wrap_dn;

    assign lim_x   = {1'b0, limit};
    assign lim_p1  = lim_x + {{WIDTH{1'b0}}, 1'b1};
    assign step_x  = {1'b0, step};
    assign cnt_x   = {1'b0, count_q};
    assign s_eff   = (step_x < lim_p1) ? step_x : lim_p1;
    assign sum_up  = cnt_x + s_eff;
    assign wrap_up = sum_up - lim_p1;
    assign diff_dn = cnt_x - s_eff;
    assign wrap_dn = cnt_x + lim_p1 - s_eff;

    logic unused_hi;
    assign unused_hi = &{1'b0, wrap_up[WIDTH], diff_dn[WIDTH], wrap_dn[WIDTH]};

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (load) begin
            count_d = (data > limit) ? limit : data;
        end else if (en && (s_eff != '0)) begin
            if (up_down) begin
                // A count left above a lowered limit is treated as a crossing.
                if (cnt_x > lim_x) begin
                    count_d = sat_mode ? limit : '0;
                    tc_d    = 1'b1;
                    ovf_set = 1'b1;
                end else if (sum_up <= lim_x) begin
                    count_d = sum_up[WIDTH-1:0];
                end else begin
                    count_d = sat_mode ? limit : wrap_up[WIDTH-1:0];
                    tc_d    = 1'b1;
                    ovf_set = 1'b1;
                end
            end else begin
                if (s_eff <= cnt_x) begin
                    count_d = diff_dn[WIDTH-1:0];
                end else begin
                    count_d = sat_mode ? '0 : wrap_dn[WIDTH-1:0];
                    tc_d    = 1'b1;
                    udf_set = 1'b1;
                end
            end
        end
        // A new crossing in the same cycle as a clear keeps the flag set.
        ovf_d = (ovf_q & ~clr_flags) | ovf_set;
        udf_d = (udf_q & ~clr_flags) | udf_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RST_VAL;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;
    assign at_max  = (count_q == limit);
    assign at_zero = (count_q == '0);

endmodule
